// File: rtl/de2i150_status_poll_pkg.sv
// Shared types and constants for the de2i150 status poll sequencer.
// State encoding, default widths and status port address.
package de2i150_status_poll_pkg;

  localparam int POLL_W_DEF = 16;
  localparam int TMO_W_DEF  = 24;

  localparam logic [1:0] STATUS_ADDR = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WAIT
  } poll_state_e;

endpackage

// File: rtl/de2i150_poll_interval_timer.sv
// Loadable down-counter that times the idle gap between status reads.
// expire is high while the count sits at 1 (last cycle of the gap).
module de2i150_poll_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  // load wins over decrement; the count parks at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/de2i150_status_poll_ctrl.sv
// Autonomous poller of the de2i150 status PIO until a masked match.
// Optional timeout logic: DE2I150_STATUS_POLL_TIMEOUT_EN.
module de2i150_status_poll_ctrl
  import de2i150_status_poll_pkg::*;
#(
  parameter int POLL_W = POLL_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       mask,
  input  logic [31:0]       match,
  input  logic [POLL_W-1:0] interval,
  input  logic [TMO_W-1:0]  timeout,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       status_snapshot,
  output logic [POLL_W-1:0] poll_count,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata
);

  poll_state_e state, state_d;

  logic [31:0]       mask_q;
  logic [31:0]       match_q;
  logic [POLL_W-1:0] interval_q;
  logic              accept;
  logic              cap_eval;
  logic              hit;
  logic              expired;
  logic              tmr_load;
  logic              tmr_exp;
  logic              done_q;

  assign accept   = (state == ST_IDLE) && start && !abort;
  assign cap_eval = (state == ST_CAPTURE) && !abort;
  assign hit      = ((avm_readdata ^ match_q) & mask_q) == '0;
  assign tmr_load = cap_eval && !hit && !expired
                    && interval_q != '0;

  assign busy        = (state != ST_IDLE);
  assign avm_read    = (state == ST_READ);
  assign avm_address = STATUS_ADDR;
  assign done        = done_q;

`ifdef DE2I150_STATUS_POLL_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] elapsed;
  logic             to_q;

  // elapsed cycles since start, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q   <= '0;
      elapsed <= '0;
      to_q    <= 1'b0;
    end else begin
      to_q <= cap_eval && !hit && expired;
      if (accept) begin
        tmo_q   <= timeout;
        elapsed <= '0;
      end else if (busy && elapsed != '1) begin
        elapsed <= elapsed + TMO_W'(1);
      end
    end
  end

  assign expired   = (tmo_q != '0) && (elapsed >= tmo_q);
  assign timed_out = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign expired        = 1'b0;
  assign timed_out      = 1'b0;
`endif

  de2i150_poll_interval_timer #(
    .W(POLL_W)
  ) u_ivl (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(interval_q),
    .en      (state == ST_WAIT),
    .expire  (tmr_exp)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // next state; abort beats everything outside IDLE
  always_comb begin
    state_d = state;
    if (abort && state != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (accept) state_d = ST_READ;
        ST_READ:    state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          if (hit || expired)        state_d = ST_IDLE;
          else if (interval_q == '0) state_d = ST_READ;
          else                       state_d = ST_WAIT;
        end
        ST_WAIT:    if (tmr_exp) state_d = ST_READ;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // command latch, read counter, snapshot and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q          <= '0;
      match_q         <= '0;
      interval_q      <= '0;
      poll_count      <= '0;
      status_snapshot <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q <= cap_eval && hit;
      if (accept) begin
        mask_q     <= mask;
        match_q    <= match;
        interval_q <= interval;
        poll_count <= '0;
      end
      if (state == ST_READ && !abort && poll_count != '1) begin
        poll_count <= poll_count + POLL_W'(1);
      end
      if (cap_eval) begin
        status_snapshot <= avm_readdata;
      end
    end
  end

endmodule
